regfile_sb: RTL and testbench



---
 rtl/regfile_sb.sv | 129 ++++++++++++
 tb/tb_regfile_sb.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with a busy scoreboard and a post-reset clear sequencer.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle write to the read ports.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic [ADDR_W-1:0] address_1,
    input  logic [ADDR_W-1:0] address_2,
    output logic [XLEN-1:0]   read_data_1,
    output logic [XLEN-1:0]   read_data_2,
    output logic              busy_1,
    output logic              busy_2,
    input  logic              write_enable_3,
    input  logic [ADDR_W-1:0] address_3,
    input  logic [XLEN-1:0]   write_data_3,
    input  logic              reserve_enable,
    input  logic [ADDR_W-1:0] reserve_address
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [XLEN-1:0]   mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [XLEN-1:0]   wr_data;
    logic              wr_ok, rsv_ok;

    assign ready  = (state_q == S_READY);
    assign wr_ok  = ready && write_enable_3 && (address_3 != '0);
    assign rsv_ok = ready && reserve_enable && (reserve_address != '0);

    // The clear sequencer and the user write share the single array write port.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wr_en   = 1'b0;
        wr_addr = address_3;
        wr_data = write_data_3;
        case (state_q)
            S_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = ptr_q;
                wr_data = '0;
                ptr_d   = ptr_q + ADDR_W'(1);
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                wr_en = wr_ok;
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            ptr_q   <= ADDR_W'(1);
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // A reservation overrides a same-edge write: it is the newer producer.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_d[gi] = 1'b0;
            end else begin : g_reg
                assign busy_d[gi] = (rsv_ok && (reserve_address == ADDR_W'(gi))) ||
                                    (busy_q[gi] && !(wr_ok && (address_3 == ADDR_W'(gi))));
            end
        end
    endgenerate

    logic [ADDR_W-1:0] rd_addr [2];
    logic [XLEN-1:0]   rd_data [2];
    logic              rd_busy [2];

    assign rd_addr[0]  = address_1;
    assign rd_addr[1]  = address_2;
    assign read_data_1 = rd_data[0];
    assign read_data_2 = rd_data[1];
    assign busy_1      = rd_busy[0];
    assign busy_2      = rd_busy[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic byp;
`ifdef REGFILE_BYPASS_EN
            assign byp = wr_ok && (rd_addr[gi] == address_3);
`else
            assign byp = 1'b0;
`endif
            always_comb begin
                rd_data[gi] = '0;
                rd_busy[gi] = 1'b0;
                if (ready) begin
                    if (byp) begin
                        rd_data[gi] = write_data_3;
                    end else if (rd_addr[gi] != '0) begin
                        rd_data[gi] = mem_q[rd_addr[gi]];
                        rd_busy[gi] = busy_q[rd_addr[gi]];
                    end
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: clear sequence, writes, scoreboard, bypass, gating, mid-run reset.
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic [4:0]  address_1, address_2, address_3, reserve_address;
    logic [31:0] read_data_1, read_data_2, write_data_3;
    logic        busy_1, busy_2, write_enable_3, reserve_enable;

    int passed = 0;
    int total  = 0;

    regfile_sb #(.XLEN(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .address_1(address_1), .address_2(address_2),
        .read_data_1(read_data_1), .read_data_2(read_data_2),
        .busy_1(busy_1), .busy_2(busy_2),
        .write_enable_3(write_enable_3), .address_3(address_3),
        .write_data_3(write_data_3),
        .reserve_enable(reserve_enable), .reserve_address(reserve_address)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; address_1 = '0; address_2 = '0; address_3 = '0;
        reserve_address = '0; write_data_3 = '0; write_enable_3 = 1'b0; reserve_enable = 1'b0;
        step();
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_rd1", read_data_1, 32'd0);
        check("reset_busy1", {31'd0, busy_1}, 32'd0);

        // Clear sequence, with an attempted write/reserve of r9 that must be ignored
        rst = 1'b0;
        write_enable_3 = 1'b1; address_3 = 5'd9; write_data_3 = 32'hFFFFFFFF;
        reserve_enable = 1'b1; reserve_address = 5'd9;
        for (int i = 1; i <= 31; i++) begin
            step();
            if (i == 1)  check("clear_edge1_ready", {31'd0, ready}, 32'd0);
            if (i == 30) begin
                check("clear_edge30_ready", {31'd0, ready}, 32'd0);
                write_enable_3 = 1'b0; reserve_enable = 1'b0;
            end
            if (i == 31) check("clear_edge31_ready", {31'd0, ready}, 32'd1);
        end
        for (int a = 0; a < 32; a++) begin
            address_1 = 5'(a); address_2 = 5'(31 - a);
            #1;
            check($sformatf("cleared_rd1_r%0d", a), read_data_1, 32'd0);
            check($sformatf("cleared_rd2_r%0d", 31 - a), read_data_2, 32'd0);
        end
        address_1 = 5'd9; #1;
        check("gated_r9_data", read_data_1, 32'd0);
        check("gated_r9_busy", {31'd0, busy_1}, 32'd0);

        // Basic write and x0
        write_enable_3 = 1'b1; address_3 = 5'd5; write_data_3 = 32'hDEADBEEF;
        step();
        address_3 = 5'd0; write_data_3 = 32'h12345678;
        step();
        write_enable_3 = 1'b0;
        address_1 = 5'd5; address_2 = 5'd0; #1;
        check("write_r5", read_data_1, 32'hDEADBEEF);
        check("write_r0", read_data_2, 32'd0);

        // Scoreboard
        reserve_enable = 1'b1; reserve_address = 5'd7;
        step();
        reserve_address = 5'd0;
        step();
        reserve_enable = 1'b0;
        address_1 = 5'd7; address_2 = 5'd0; #1;
        check("reserve_r7_busy", {31'd0, busy_1}, 32'd1);
        check("reserve_r0_busy", {31'd0, busy_2}, 32'd0);
        write_enable_3 = 1'b1; address_3 = 5'd7; write_data_3 = 32'hA5A5A5A5; #1;
`ifdef REGFILE_BYPASS_EN
        check("wr_r7_same_cycle_data", read_data_1, 32'hA5A5A5A5);
        check("wr_r7_same_cycle_busy", {31'd0, busy_1}, 32'd0);
`else
        check("wr_r7_same_cycle_data", read_data_1, 32'd0);
        check("wr_r7_same_cycle_busy", {31'd0, busy_1}, 32'd1);
`endif
        step();
        write_enable_3 = 1'b0; #1;
        check("wr_r7_busy_cleared", {31'd0, busy_1}, 32'd0);
        check("wr_r7_data", read_data_1, 32'hA5A5A5A5);
        write_enable_3 = 1'b1; address_3 = 5'd7; write_data_3 = 32'h5A5A5A5A;
        reserve_enable = 1'b1; reserve_address = 5'd7;
        step();
        write_enable_3 = 1'b0; reserve_enable = 1'b0; #1;
        check("wr_rsv_r7_busy", {31'd0, busy_1}, 32'd1);
        check("wr_rsv_r7_data", read_data_1, 32'h5A5A5A5A);

        // Same-cycle write visibility on r3
        address_1 = 5'd3;
        write_enable_3 = 1'b1; address_3 = 5'd3; write_data_3 = 32'h0000CAFE; #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_r3_same_cycle", read_data_1, 32'h0000CAFE);
`else
        check("byp_r3_same_cycle", read_data_1, 32'd0);
`endif
        check("byp_r3_busy", {31'd0, busy_1}, 32'd0);
        step();
        write_enable_3 = 1'b0; #1;
        check("byp_r3_next_cycle", read_data_1, 32'h0000CAFE);

        // Reset mid-operation
        reserve_enable = 1'b1; reserve_address = 5'd4;
        write_enable_3 = 1'b1; address_3 = 5'd6; write_data_3 = 32'h00001111;
        step();
        reserve_enable = 1'b0; write_enable_3 = 1'b0;
        address_1 = 5'd6; address_2 = 5'd4; #1;
        check("pre_rst_r6", read_data_1, 32'h00001111);
        check("pre_rst_r4_busy", {31'd0, busy_2}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_ready", {31'd0, ready}, 32'd0);
        check("mid_rst_rd1", read_data_1, 32'd0);
        for (int i = 1; i <= 31; i++) begin
            step();
            if (i == 30) check("reclear_edge30_ready", {31'd0, ready}, 32'd0);
            if (i == 31) check("reclear_edge31_ready", {31'd0, ready}, 32'd1);
        end
        check("post_rst_r6", read_data_1, 32'd0);
        check("post_rst_r4_busy", {31'd0, busy_2}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
